// File: rtl/turbo_enc_sched_pkg.sv
// rsc_lib: RSC step, termination bit, interleaver and scheduler state type
package rsc_lib;
  typedef enum logic [2:0] {IDLE, LOAD, ENC, TERM, DRAIN} tsched_state_t;
  function automatic logic [2:0] rsc_encode(input logic u, input logic [1:0] s);
    logic fb;
    fb = u ^ s[0] ^ s[1];
    return {fb ^ s[1], s[0], fb};
  endfunction
  function automatic logic rsc_term_bit(input logic [1:0] s);
    return s[0] ^ s[1];
  endfunction
  function automatic int unsigned interleave_index(input int unsigned i, input int unsigned k);
    return (7 * i) % k;
  endfunction
endpackage

// File: rtl/turbo_frame_buf.sv
// turbo_frame_buf: bit buffer with one write port and natural/interleaved read ports
module turbo_frame_buf #(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic          wd,
  input  logic [AW-1:0] ra_nat,
  input  logic [AW-1:0] ra_int,
  output logic          rd_nat,
  output logic          rd_int
);
  logic mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  assign rd_nat = mem[ra_nat];
  assign rd_int = mem[ra_int];
endmodule

// File: rtl/turbo_enc_sched.sv
// turbo_enc_sched: frame buffering, dual RSC encoding and trellis termination scheduler
module turbo_enc_sched
  import rsc_lib::*;
#(
  parameter int MAX_K = 64,
  parameter int MIN_K = 2,
  parameter int KW = $clog2(MAX_K + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] cfg_k,
  output logic          busy,
  output logic          cfg_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sys,
  output logic          out_sys2,
  output logic          out_p1,
  output logic          out_p2,
  output logic          out_tail,
  output logic          out_last,
  output logic          done
);
  localparam int AW = $clog2(MAX_K);
  tsched_state_t state, state_n;
  logic [KW-1:0] k, k_n, idx, idx_n;
  logic [AW-1:0] iidx;
  logic [1:0] s1, s1_n, s2, s2_n;
  logic [5:0] beat, beat_n;
  logic [2:0] e1, e2;
  logic tcnt, tcnt_n, ov_n, cfg_err_n, u1, u2, t1, t2, slot, k_ok;
  turbo_frame_buf #(.DEPTH(MAX_K), .AW(AW)) u_buf (
    .clk(clk),
    .we(state == LOAD && in_valid),
    .wa(idx[AW-1:0]),
    .wd(in_bit),
    .ra_nat(idx[AW-1:0]),
    .ra_int(iidx),
    .rd_nat(u1),
    .rd_int(u2)
  );
  assign iidx = AW'(interleave_index(32'(idx), 32'(k)));
  assign k_ok = cfg_k >= KW'(MIN_K) && cfg_k <= KW'(MAX_K);
  assign slot = !out_valid || out_ready;
  assign t1 = rsc_term_bit(s1);
  assign t2 = rsc_term_bit(s2);
  assign e1 = rsc_encode(state == TERM ? t1 : u1, s1);
  assign e2 = rsc_encode(state == TERM ? t2 : u2, s2);
  assign busy = state != IDLE;
  assign in_ready = state == LOAD;
  assign {out_sys, out_sys2, out_p1, out_p2, out_tail, out_last} = beat;
  assign done = out_valid && out_ready && out_last;
  always_comb begin
    state_n = state;
    k_n = k;
    idx_n = idx;
    s1_n = s1;
    s2_n = s2;
    tcnt_n = tcnt;
    beat_n = beat;
    ov_n = out_valid;
    cfg_err_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        cfg_err_n = !k_ok;
        if (k_ok) begin
          state_n = LOAD;
          k_n = cfg_k;
          idx_n = '0;
          s1_n = 2'b00;
          s2_n = 2'b00;
        end
      end
      LOAD: if (in_valid) begin
        idx_n = idx == k - 1'b1 ? '0 : idx + 1'b1;
        state_n = idx == k - 1'b1 ? ENC : LOAD;
      end
      ENC: if (slot) begin
        beat_n = {u1, 1'b0, e1[2], e2[2], 2'b00};
        ov_n = 1'b1;
        s1_n = e1[1:0];
        s2_n = e2[1:0];
        idx_n = idx + 1'b1;
        tcnt_n = 1'b0;
        state_n = idx == k - 1'b1 ? TERM : ENC;
      end
      TERM: if (slot) begin
        beat_n = {t1, t2, e1[2], e2[2], 1'b1, tcnt};
        ov_n = 1'b1;
        s1_n = e1[1:0];
        s2_n = e2[1:0];
        tcnt_n = 1'b1;
        state_n = tcnt ? DRAIN : TERM;
      end
      DRAIN: if (out_ready) begin
        ov_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      idx <= '0;
      s1 <= 2'b00;
      s2 <= 2'b00;
      tcnt <= 1'b0;
      beat <= '0;
      out_valid <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      idx <= idx_n;
      s1 <= s1_n;
      s2 <= s2_n;
      tcnt <= tcnt_n;
      beat <= beat_n;
      out_valid <= ov_n;
      cfg_err <= cfg_err_n;
    end
  end
  assert property (@(posedge clk) disable iff (rst) state == DRAIN |-> s1 == 2'b00 && s2 == 2'b00);
endmodule

// File: tb/tb_turbo_enc_sched.sv
// tb_turbo_enc_sched: scoreboard bench comparing beats against a feedback-sequence model
module tb_turbo_enc_sched;
  localparam int MAX_K = 64;
  localparam int MIN_K = 2;
  localparam int KW = $clog2(MAX_K + 1);
  logic clk = 1'b0;
  logic rst, start, in_valid, in_bit;
  logic out_ready = 1'b1;
  logic [KW-1:0] cfg_k;
  logic busy, cfg_err, in_ready, out_valid, out_sys, out_sys2, out_p1, out_p2, out_tail, out_last, done;
  logic [5:0] exp_q[$];
  logic [5:0] cap_q[$];
  int checks = 0;
  int errors = 0;
  logic rnd_rdy = 1'b0;
  logic rnd_gap = 1'b0;
  turbo_enc_sched #(.MAX_K(MAX_K), .MIN_K(MIN_K)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .busy(busy), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_sys(out_sys), .out_sys2(out_sys2),
    .out_p1(out_p1), .out_p2(out_p2), .out_tail(out_tail), .out_last(out_last), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  function automatic void model(input int kk, input logic [MAX_K-1:0] x);
    logic a1[$];
    logic a2[$];
    logic u1, u2, tl;
    int n;
    a1 = '{1'b0, 1'b0};
    a2 = '{1'b0, 1'b0};
    for (int t = 0; t < kk + 2; t++) begin
      n = a1.size();
      tl = t >= kk;
      u1 = tl ? a1[n-1] ^ a1[n-2] : x[t];
      u2 = tl ? a2[n-1] ^ a2[n-2] : x[(7 * t) % kk];
      a1.push_back(u1 ^ a1[n-1] ^ a1[n-2]);
      a2.push_back(u2 ^ a2[n-1] ^ a2[n-2]);
      exp_q.push_back({u1, tl & u2, a1[n] ^ a1[n-2], a2[n] ^ a2[n-2], tl, 1'(t == kk + 1)});
    end
  endfunction
  function automatic logic [7:0] cap_bits(input int pos);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8 && i < cap_q.size(); i++) v[i] = cap_q[i][pos];
    return v;
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_beat", out_valid, 0);
      else begin
        chk("beat_fields", {out_sys, out_sys2, out_p1, out_p2, out_tail, out_last, done},
            {exp_q[0], out_ready & exp_q[0][0]});
        if (out_ready) begin
          cap_q.push_back({out_sys, out_sys2, out_p1, out_p2, out_tail, out_last});
          void'(exp_q.pop_front());
        end
      end
    end
  end
  task automatic start_frame(input int kk, input logic [MAX_K-1:0] x);
    model(kk, x);
    cap_q.delete();
    start = 1'b1;
    cfg_k = KW'(kk);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_inready_after_start", {busy, in_ready, cfg_err}, 3'b110);
    for (int i = 0; i < kk; i++) begin
      if (rnd_gap) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_bit = x[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    chk("no_beat_before_first_slot", out_valid, 0);
    @(posedge clk);
    #1;
    chk("first_beat_latency", out_valid, 1);
  endtask
  task automatic finish_frame(input int kk);
    int n = 0;
    int nv = 0;
    while (busy && n < 4000) begin
      nv += int'(out_valid);
      @(posedge clk);
      #1;
      n++;
    end
    chk("frame_terminates", 64'(n < 4000), 1);
    if (!rnd_rdy) chk("beats_without_bubbles", nv, kk + 2);
    chk("frame_beat_count", cap_q.size(), kk + 2);
    chk("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int bad[3];
    int n, kk;
    logic [MAX_K-1:0] x;
    bad = '{1, MAX_K + 1, 0};
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    cfg_k = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, cfg_err, in_ready, out_valid, out_sys, out_sys2, out_p1, out_p2,
        out_tail, out_last, done}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_frame(4, '0);
    finish_frame(4);
    chk("zero_tail_flags", {cap_q[4][1:0], cap_q[5][1:0]}, 4'b1011);
    start_frame(8, 64'h1);
    finish_frame(8);
    chk("impulse_p1", cap_bits(3), 8'b10110111);
    chk("impulse_p2", cap_bits(2), 8'b10110111);
    chk("impulse_tail0", cap_q[8], 6'b001110);
    chk("impulse_tail1", cap_q[9], 6'b111111);
    start_frame(8, 64'h2);
    finish_frame(8);
    chk("interleave_p2", cap_bits(2), 8'b10000000);
    rnd_rdy = 1'b1;
    start_frame(8, 64'h1);
    finish_frame(8);
    chk("bp_impulse_p1", cap_bits(3), 8'b10110111);
    chk("bp_impulse_tail1", cap_q[9], 6'b111111);
    rnd_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      cfg_k = KW'(bad[i]);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("cfg_err_pulse", {cfg_err, busy}, 2'b10);
      @(posedge clk);
      #1;
      chk("cfg_err_one_cycle", {cfg_err, busy}, 2'b00);
    end
    start_frame(8, 64'hA5);
    n = 0;
    while (cap_q.size() < 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_beat3", 64'(cap_q.size() >= 3), 1);
    rst = 1'b1;
    #1;
    chk("reset_mid_frame", {out_valid, busy, in_ready, done}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", {out_valid, busy}, 0);
    rst = 1'b0;
    start_frame(4, '0);
    finish_frame(4);
    rnd_gap = 1'b1;
    repeat (8) begin
      kk = $urandom_range(MIN_K, MAX_K);
      rnd_rdy = 1'($urandom_range(0, 1));
      x = {$urandom, $urandom};
      start_frame(kk, x);
      finish_frame(kk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/turbo_enc_sched.md
# turbo_enc_sched

Frame scheduler and controller for the turbo encoder datapath. It accepts one frame of K information bits and buffers it. It then drives two RSC constituent encoders, RSC1 in natural order and RSC2 in interleaved order, one index per beat. It finishes with two trellis-termination beats that return both encoders to state 0. It sits between the bit source and the rate-1/3 output packer, and owns encoder state, the index counter and frame sequencing.

## Interface
- `MAX_K`, default 64: maximum frame length in bits.
- `MIN_K`, default 2: minimum legal frame length.
- `KW`, default `$clog2(MAX_K+1)`: width of the length and index fields.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: frame request, sampled only in IDLE.
- `cfg_k`  in  KW: frame length, latched on `start`.
- `busy`  out  1: high in every state except IDLE.
- `cfg_err`  out  1: one-cycle pulse when `start` carries an illegal `cfg_k`.
- `in_valid` / `in_ready` / `in_bit`  in / out / in  1 each: input bit handshake.
- `out_valid` / `out_ready`  out / in  1 each: output beat handshake.
- `out_sys`  out  1: systematic bit; during tail beats, the RSC1 termination input.
- `out_sys2`  out  1: RSC2 termination input; 0 on data beats.
- `out_p1`, `out_p2`  out  1 each: RSC1 and RSC2 parity.
- `out_tail`  out  1: beat is a termination beat.
- `out_last`  out  1: final beat of the frame.
- `done`  out  1: one-cycle pulse on the handshake of the final beat.

## Operation
- States: IDLE, LOAD, ENC, TERM, DRAIN.
- **IDLE**
  - `start` with `MIN_K <= cfg_k <= MAX_K`: latch K, clear index to 0, clear both encoder states to 2'b00, go to LOAD.
  - Illegal `cfg_k`: pulse `cfg_err`, stay in IDLE.
- **LOAD**
  - `in_ready`=1 only in this state.
  - Each `in_valid && in_ready` writes `in_bit` to `buf[idx]` and increments idx.
  - The handshake at idx=K-1 moves to ENC with idx reset to 0.
- **ENC**, one beat per free output slot. A slot is free when `!out_valid || out_ready`.
  - u1 = `buf[idx]`; u2 = `buf[interleave_index(idx,K)]`.
  - Beat = {sys=u1, p1, p2, sys2=0, tail=0}.
  - Encoders advance only when a beat is loaded.
  - After loading idx=K-1, go to TERM with tail count 0.
- **RSC step** (identical for both encoders, state s[1:0]):
  - fb = u^s[0]^s[1]
  - parity = fb^s[1]
  - next = {s[0], fb}
- **TERM**, 2 beats.
  - Per encoder, t = s[0]^s[1], so fb=0 and parity = s[1].
  - Beat = {sys=t1, sys2=t2, p1, p2, tail=1}.
  - The second tail beat sets `out_last`=1; then go to DRAIN.
  - Both encoder states must be 0 after the second tail beat. A nonzero state is a design error, checked by assertion.
- **DRAIN**: on the handshake of the last beat, pulse `done` and go to IDLE.
- Ignored inputs:
  - `start` is ignored while `busy`.
  - `in_valid` is ignored outside LOAD.
- Reset at any time:
  - All state returns to IDLE, encoder states to 00, idx to 0.
  - Outputs return to their reset values.
  - Buffer contents are don't-care.

## Timing
- Reset values: `busy`, `cfg_err`, `in_ready`, `out_valid` and every `out_*` data bit, and `done` are all 0.
- `start` at edge t: `busy` and `in_ready` are 1 from t+1.
- Last input handshake at edge t: the first data beat is registered at edge t+1, so `out_valid`=1 during cycle t+1 to t+2.
- With `out_ready` held at 1, the frame is exactly K+2 consecutive beats, one per cycle, with no bubbles.
- Backpressure: beat fields hold stable while `out_valid && !out_ready`; encoder state and idx do not advance.
- `done` pulses in the handshake cycle of the `out_last` beat; `busy`=0 the next cycle.
- A new `start` is accepted in the first IDLE cycle.

## Structure
- Package `rsc_lib` holds:
  - `rsc_encode` (step above);
  - `rsc_term_bit(s)` = s[0]^s[1];
  - `interleave_index(i,K)` = (7*i) mod K;
  - the state enum `tsched_state_t`.
- Sub-module `turbo_frame_buf`: MAX_K×1 flop array with one synchronous write port and two combinational read ports (natural and interleaved address).

## Test plan
- **All-zero frame**: K=4, bits 0000, `out_ready`=1.
  - Required: 6 beats, every bit 0.
  - Beats 5-6 have `out_tail`=1; beat 6 has `out_last`=1 and `done` pulses.
- **Impulse frame**: K=8, x=1,0,0,0,0,0,0,0.
  - Required p1 = p2 = 1,1,1,0,1,1,0,1.
  - Tail beats: sys = sys2 = 0 then 1; p1 = p2 = 1 then 1.
  - Both encoder states end at 00.
- **Interleave order**: K=8, x=0,1,0,0,0,0,0,0.
  - RSC2 input sequence is x[0],x[7],x[6],x[5],x[4],x[3],x[2],x[1], so u2=1 at beat 7.
  - Required: p2 is 0 for beats 0-6 and 1 at beat 7.
- **Backpressure**: impulse frame with `out_ready` toggling randomly.
  - Beat sequence must be identical to the `out_ready`=1 run.
  - Fields must hold stable while stalled.
- **Illegal length**: `start` with `cfg_k`=1 and with `cfg_k`=MAX_K+1.
  - Required: `cfg_err` pulses for one cycle; `busy` stays 0.
- **Reset mid-frame**: assert `rst` during ENC at beat 3, release, start a K=4 zero frame.
  - Required: `out_valid`=0 during reset, then a clean 6-beat all-zero frame.
